// File: rtl/tmc_scan_sequencer_if.sv
// rtl/tmc_scan_sequencer_if.sv - control, SPI pin and result signals of the scan sequencer
interface tmc_scan_sequencer_if #(
  parameter int XFER_BITS = 24
);
  logic                 start;
  logic                 continuous;
  logic [3:0]           live;
  logic [11:0]          chan_en;
  logic [XFER_BITS-1:0] cmd_word;
  logic                 miso;
  logic                 mosi;
  logic                 sclk;
  logic [11:0]          csn;
  logic                 busy;
  logic                 res_valid;
  logic [3:0]           res_chan;
  logic [XFER_BITS-1:0] res_data;
  logic                 scan_done;

  modport slave (
    input  start, continuous, live, chan_en, cmd_word, miso,
    output mosi, sclk, csn, busy, res_valid, res_chan, res_data, scan_done
  );

  modport master (
    output start, continuous, live, chan_en, cmd_word, miso,
    input  mosi, sclk, csn, busy, res_valid, res_chan, res_data, scan_done
  );
endinterface

// File: rtl/tmc_scan_sequencer.sv
// rtl/tmc_scan_sequencer.sv - 12-channel SPI scan sequencer; TMC_SCAN_LIVE_SKIP_EN enables live-board skipping
module tmc_scan_sequencer #(
  parameter int CLK_DIV       = 4,
  parameter int XFER_BITS     = 24,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tmc_scan_sequencer_if.slave   bus
);

  localparam int CNT_MAX = (SETTLE_CYCLES > 2 * CLK_DIV) ? SETTLE_CYCLES : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(XFER_BITS);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF        = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(XFER_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SELECT,
    S_SHIFT,
    S_DESELECT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [XFER_BITS-1:0] sh_q, sh_d;
  logic [XFER_BITS-1:0] rx_q, rx_d;
  logic                 mosi_q, mosi_d;
  logic                 sclk_q, sclk_d;
  logic [11:0]          csn_q, csn_d;
  logic                 busy_q, busy_d;
  logic                 res_valid_q, res_valid_d;
  logic [3:0]           res_chan_q, res_chan_d;
  logic [XFER_BITS-1:0] res_data_q, res_data_d;
  logic                 scan_done_q, scan_done_d;
  logic                 eligible;
  logic                 cs_active;

`ifdef TMC_SCAN_LIVE_SKIP_EN
  logic [3:0] live_meta_q, live_meta_d;
  logic [3:0] live_s_q, live_s_d;
  logic [1:0] board;

  // two-flop synchronizer inputs for the asynchronous board-present lines
  always_comb begin
    live_meta_d = bus.live;
    live_s_d    = live_meta_q;
  end

  // synchronizer flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_meta_q <= 4'h0;
      live_s_q    <= 4'h0;
    end else begin
      live_meta_q <= live_meta_d;
      live_s_q    <= live_s_d;
    end
  end

  assign board    = 2'(idx_q / 4'd3);
  assign eligible = bus.chan_en[idx_q] && live_s_q[board];
`else
  assign eligible = bus.chan_en[idx_q];
`endif

  // next-state logic; every output is computed from the next state so it leaves a flop
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    res_valid_d = 1'b0;
    res_chan_d  = res_chan_q;
    res_data_d  = res_data_q;
    cs_active   = 1'b0;
    csn_d       = 12'hFFF;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SCAN;
          idx_d   = 4'd0;
        end
      end
      S_SCAN: begin
        if (eligible) begin
          state_d = S_SELECT;
          cnt_d   = '0;
          sh_d    = bus.cmd_word;
        end else if (idx_q == 4'd11) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SELECT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // this edge raises sclk, so it is the MISO sampling edge
        if (cnt_q == HALF_LAST) begin
          rx_d = {rx_q[XFER_BITS-2:0], bus.miso};
        end
        if (cnt_q == PERIOD_LAST) begin
          cnt_d = '0;
          sh_d  = {sh_q[XFER_BITS-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            state_d     = S_DESELECT;
            res_valid_d = 1'b1;
            res_chan_d  = idx_q;
            res_data_d  = rx_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DESELECT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd11) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        idx_d   = 4'd0;
        state_d = bus.continuous ? S_SCAN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cs_active = (state_d == S_SELECT) || (state_d == S_SHIFT);
    for (int k = 0; k < 12; k++) begin
      csn_d[k] = ~(cs_active && (idx_d == 4'(k)));
    end
    sclk_d      = (state_d == S_SHIFT) && (cnt_d >= HALF);
    mosi_d      = (state_d == S_SHIFT) ? sh_d[XFER_BITS-1] : 1'b0;
    busy_d      = (state_d != S_IDLE);
    scan_done_d = (state_d == S_DONE);
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      csn_q       <= 12'hFFF;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_chan_q  <= 4'd0;
      res_data_q  <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      csn_q       <= csn_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_chan_q  <= res_chan_d;
      res_data_q  <= res_data_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.mosi      = mosi_q;
  assign bus.sclk      = sclk_q;
  assign bus.csn       = csn_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_chan  = res_chan_q;
  assign bus.res_data  = res_data_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_tmc_scan_sequencer.sv
// tb/tb_tmc_scan_sequencer.sv - table-driven and sequence checks for tmc_scan_sequencer
module tb_tmc_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  tmc_scan_sequencer_if #(.XFER_BITS(24)) bus ();

  tmc_scan_sequencer #(
    .CLK_DIV      (2),
    .XFER_BITS    (24),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  live;
    logic [11:0] en;
    logic [23:0] cmd;
    logic [23:0] miso;
    logic [11:0] mask;
    int          n;
    int          cs_first;
    int          res_first;
    int          done;
  } vec_t;

  vec_t vecs[4];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          miso_rises = 0;
  int          multi_cs = 0;
  logic        rise = 1'b0;
  logic        prev_sclk = 1'b0;
  logic [23:0] miso_word = 24'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock; sampling and the MISO slave model run on the falling edge
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rise      = bus.sclk && !prev_sclk;
    prev_sclk = bus.sclk;
    if (bus.csn == 12'hFFF) miso_rises = 0;
    else if (rise) miso_rises++;
    bus.miso = (miso_rises < 24) ? miso_word[23 - miso_rises] : 1'b0;
    if ($countones(~bus.csn) > 1) multi_cs++;
  endtask

  initial begin
    int          done_cyc, nres, data_err, order_err, last_chan, cs_first, res_first, rises;
    int          n_done, done1, done2, busy_after, cs_after, rv_seen, busy_seen, cs_seen, idle_err;
    logic [11:0] rmask, csmask;
    logic [23:0] mosi_w;

    vecs[0] = '{4'hF, 12'h001, 24'hA5F00F, 24'h123456, 12'h001, 1, 2, 102, 117};
`ifdef TMC_SCAN_LIVE_SKIP_EN
    vecs[1] = '{4'b0101, 12'hFFF, 24'h3C3C3C, 24'hABCDEF, 12'h1C7, 6, 2, 102, 637};
    vecs[2] = '{4'h0, 12'hFFF, 24'h000000, 24'h000000, 12'h000, 0, 0, 0, 13};
`else
    vecs[1] = '{4'b0101, 12'hFFF, 24'h3C3C3C, 24'hABCDEF, 12'hFFF, 12, 2, 102, 1261};
    vecs[2] = '{4'h0, 12'hFFF, 24'h000000, 24'h000000, 12'hFFF, 12, 2, 102, 1261};
`endif
    vecs[3] = '{4'hF, 12'h800, 24'h800001, 24'h5A5A5A, 12'h800, 1, 13, 113, 117};

    bus.start = 1'b0; bus.continuous = 1'b0; bus.live = 4'h0; bus.chan_en = 12'h0;
    bus.cmd_word = 24'h0; bus.miso = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("por_csn", 32'(bus.csn), 32'hFFF);
    check("por_sclk", 32'(bus.sclk), 0);
    check("por_busy", 32'(bus.busy), 0);
    check("por_res_chan", 32'(bus.res_chan), 0);
    check("por_res_data", 32'(bus.res_data), 0);
    rst_n = 1'b1;
    tick();

    // table-driven single scans
    for (int r = 0; r < 4; r++) begin
      bus.live = vecs[r].live; bus.chan_en = vecs[r].en; bus.cmd_word = vecs[r].cmd;
      miso_word = vecs[r].miso;
      repeat (3) tick();
      multi_cs = 0;
      done_cyc = 0; nres = 0; data_err = 0; order_err = 0; last_chan = -1;
      cs_first = 0; res_first = 0; rises = 0; rmask = 0; csmask = 0; mosi_w = 0;
      bus.start = 1'b1;
      cyc = 0;
      tick();
      bus.start = 1'b0;
      while (done_cyc == 0 && cyc < 2000) begin
        if (bus.csn != 12'hFFF) begin
          csmask |= ~bus.csn;
          if (cs_first == 0) cs_first = cyc;
        end
        if (rise) begin
          rises++;
          if (nres == 0) mosi_w = {mosi_w[22:0], bus.mosi};
        end
        if (bus.res_valid) begin
          if (nres == 0) res_first = cyc;
          nres++;
          rmask[bus.res_chan] = 1'b1;
          if (bus.res_data !== vecs[r].miso) data_err++;
          if (int'(bus.res_chan) <= last_chan) order_err++;
          last_chan = int'(bus.res_chan);
        end
        if (bus.scan_done) done_cyc = cyc;
        else tick();
      end
      check($sformatf("row%0d_done_cycle", r), 32'(done_cyc), 32'(vecs[r].done));
      check($sformatf("row%0d_result_count", r), 32'(nres), 32'(vecs[r].n));
      check($sformatf("row%0d_result_chans", r), 32'(rmask), 32'(vecs[r].mask));
      check($sformatf("row%0d_csn_low_chans", r), 32'(csmask), 32'(vecs[r].mask));
      check($sformatf("row%0d_data_errs", r), 32'(data_err), 0);
      check($sformatf("row%0d_order_errs", r), 32'(order_err), 0);
      check($sformatf("row%0d_multi_csn", r), 32'(multi_cs), 0);
      check($sformatf("row%0d_sclk_rises", r), 32'(rises), 32'(24 * vecs[r].n));
      if (vecs[r].n > 0) begin
        check($sformatf("row%0d_mosi_word", r), 32'(mosi_w), 32'(vecs[r].cmd));
        check($sformatf("row%0d_csn_first", r), 32'(cs_first), 32'(vecs[r].cs_first));
        check($sformatf("row%0d_res_first", r), 32'(res_first), 32'(vecs[r].res_first));
      end
      tick();
      check($sformatf("row%0d_busy_after", r), 32'(bus.busy), 0);
    end

    // asynchronous reset at bit 10 of channel 0, then idle without start
    bus.live = 4'hF; bus.chan_en = 12'h001; bus.cmd_word = 24'hA5F00F; miso_word = 24'h123456;
    repeat (3) tick();
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
    while (cyc < 47) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_csn", 32'(bus.csn), 32'hFFF);
    check("rst_sclk", 32'(bus.sclk), 0);
    check("rst_mosi", 32'(bus.mosi), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 0; busy_seen = 0; cs_seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.res_valid) rv_seen++;
      if (bus.busy) busy_seen++;
      if (bus.csn != 12'hFFF) cs_seen++;
    end
    check("post_rst_res_valid", 32'(rv_seen), 0);
    check("post_rst_busy", 32'(busy_seen), 0);
    check("post_rst_csn", 32'(cs_seen), 0);

    // continuous mode, ignored start, continuous dropped mid-scan
    bus.chan_en = 12'h003;
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
    n_done = 0; done1 = 0; done2 = 0; busy_after = -1; cs_after = 0; idle_err = 0;
    while (cyc < 700) begin
      if (cyc == 100) bus.start = 1'b1;
      if (cyc == 101) bus.start = 1'b0;
      if (cyc == 300) bus.continuous = 1'b0;
      if (bus.scan_done) begin
        n_done++;
        if (n_done == 1) done1 = cyc;
        if (n_done == 2) done2 = cyc;
      end
      if (done1 != 0 && cyc == done1 + 1) busy_after = int'(bus.busy);
      if (done1 != 0 && cs_after == 0 && cyc > done1 && bus.csn[0] == 1'b0) cs_after = cyc;
      if (done2 != 0 && cyc > done2 && bus.busy) idle_err++;
      tick();
    end
    check("cont_done_count", 32'(n_done), 2);
    check("cont_done1_cycle", 32'(done1), 221);
    check("cont_done2_cycle", 32'(done2), 442);
    check("cont_busy_after_done", 32'(busy_after), 1);
    check("cont_csn_reentry", 32'(cs_after), 223);
    check("cont_idle_after_stop", 32'(idle_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmc_scan_sequencer.md
# tmc_scan_sequencer

Hardware scan controller for the four temperature readout boards (A–D, three SPI chip selects each, 12 channels total). It sequences SPI transactions through every enabled channel in fixed order, skips boards whose `live` line is low, and presents each captured word with its channel number. It drives the shared MOSI/SCLK and the 12 active-low chip selects, so the Nios II SPI core no longer has to handle per-channel timing. It sits between the top-level board pin muxing and the processor PIO/register interface.

## Interface
- `CLK_DIV`, 4, clk cycles per SCLK half-period (≥1)
- `XFER_BITS`, 24, bits per transaction (2–32)
- `SETTLE_CYCLES`, 16, clk cycles CS-low before first SCLK edge, and CS-high hold after transaction (≥1)

- `clk` in 1: logic clock
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: level sampled in IDLE; begins one scan
- `continuous` in 1: when high at DONE, next scan begins without `start`
- `live` in 4: board-present lines [0]=A..[3]=D, asynchronous; 2-flop synchronized internally
- `chan_en` in 12: per-channel enable; channel k is on board k/3
- `cmd_word` in XFER_BITS: word shifted out each transaction, captured at SELECT entry
- `miso` in 1: demuxed MISO from the active board
- `mosi` out 1: serial data, MSB first
- `sclk` out 1: SPI clock, mode 0, idles low
- `csn` out 12: chip selects, active low, at most one low
- `busy` out 1: high in any state except IDLE
- `res_valid` out 1: one-cycle result strobe
- `res_chan` out 4: channel 0–11 of the result; held until the next strobe
- `res_data` out XFER_BITS: captured MISO word; held until the next strobe
- `scan_done` out 1: one-cycle pulse at end of scan

## Operation
- States: IDLE, SCAN, SELECT, SHIFT, DESELECT, DONE.
- IDLE → SCAN when `start`=1; channel index `idx` := 0.
- SCAN evaluates one channel per cycle. Eligible = `chan_en[idx]` && `live_s[idx/3]`.
  - Eligible → SELECT.
  - Not eligible, `idx`=11 → DONE.
  - Otherwise `idx`++ and stay in SCAN.
- SELECT: `csn[idx]`=0 and `cmd_word` latched into the shift register; lasts SETTLE_CYCLES, then → SHIFT.
- SHIFT: XFER_BITS bits, 2·CLK_DIV cycles each.
  - `mosi` = current MSB for the whole bit.
  - `sclk` low for the first CLK_DIV cycles, high for the last CLK_DIV.
  - `miso` is sampled into the receive register LSB on the clk edge that raises `sclk`.
  - After the last bit, `sclk`=0 → DESELECT.
- DESELECT: `csn` all 1, `mosi`=0; lasts SETTLE_CYCLES.
  - First cycle: `res_valid`=1, `res_chan`=`idx`, `res_data`=receive register.
  - Exit: if `idx`=11 → DONE, else `idx`++ → SCAN.
- DONE: `scan_done`=1 for one cycle.
  - `continuous`=1 → SCAN with `idx`:=0.
  - Otherwise → IDLE.
- `start` outside IDLE is ignored. Dropping `continuous` mid-scan lets the current scan finish, then IDLE.
- `live` or `chan_en` changing mid-transaction does not abort it. Eligibility is evaluated only in SCAN.
- No eligible channel: 12 SCAN cycles, then DONE. No `csn` activity, no `res_valid`.
- Reset (asynchronous, any state):
  - `csn`=12'hFFF, `sclk`=0, `mosi`=0, `busy`=0.
  - `res_valid`=0, `scan_done`=0, `res_chan`=0, `res_data`=0.
  - `live_s`=0. State = IDLE.
  - An interrupted transaction produces no result.

## Timing
- All outputs are registered. `live` reaches `live_s` 2 clk cycles after it changes.
- `start` sampled high at edge 0: SCAN at cycle 1.
- First eligible channel at `idx`=0:
  - `csn` low from cycle 2.
  - SHIFT starts at cycle 2+SETTLE_CYCLES.
  - `res_valid` at cycle 2+SETTLE_CYCLES+2·CLK_DIV·XFER_BITS.
- Per-transaction cost: 2·SETTLE_CYCLES + 2·CLK_DIV·XFER_BITS, plus 1 SCAN cycle.
- Each skipped channel costs 1 cycle.

## Configuration
- `TMC_SCAN_LIVE_SKIP_EN` defined: eligibility includes `live_s[idx/3]`, as described above.
- Not defined: `live` and its synchronizer are removed. Eligibility = `chan_en[idx]` only, so channels on absent boards are read (their data is undefined).

## Test plan
Parameters for all scenarios: CLK_DIV=2, XFER_BITS=24, SETTLE_CYCLES=4, macro defined.
- **Reset values:** assert `rst_n`=0 mid-run → `csn`=12'hFFF, `sclk`=0, `mosi`=0, `busy`=0, `res_valid`=0 immediately (asynchronous).
- **Single channel:** `live`=4'hF held ≥2 cycles, `chan_en`=12'h001, `cmd_word`=24'hA5F00F, MISO model returns 24'h123456, `start` at edge 0.
  - `csn[0]` low cycles 2–101.
  - 24 `sclk` rising edges; `mosi` bits = 0xA5F00F.
  - `res_valid` at cycle 102 with `res_chan`=0, `res_data`=24'h123456.
  - `scan_done` at cycle 117; `busy`=0 from cycle 118.
- **Board skipping:** `live`=4'b0101, `chan_en`=12'hFFF → `res_chan` sequence 0,1,2,6,7,8, then `scan_done`; `csn[3..5]` and `csn[9..11]` never low.
- **No eligible channels:** `live`=0 → `scan_done` at cycle 13, `csn` stays 12'hFFF, no `res_valid`.
- **Continuous mode:** `continuous`=1, `chan_en`=12'h003.
  - After `scan_done`, SCAN re-enters the next cycle.
  - `start` pulsed while `busy` → no effect.
  - Clear `continuous` mid-scan → exactly one further `scan_done`, then IDLE.
- **Reset mid-SHIFT:** assert reset at bit 10 of channel 0 → no `res_valid`; after release, stays IDLE until `start`.
